pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
Instruction-fetch front end of the 5-stage MIPS pipeline. Holds the program counter and drives it to the PC+INCR adder, which sits directly downstream. Consumes the adder's sum as the sequential next PC. Issues instruction-memory requests, applies branch redirects and stalls, and loads the IF/ID pipeline register.

Parameters:
WIDTH, 32, PC/address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
INCR, 4, constant driven to the adder's second operand

Ports:
clk__i  in  1  pipeline clock, rising edge
rst_n__i  in  1  asynchronous active-low reset
stall__i  in  1  hazard-unit stall; hold PC and IF/ID
branch_taken__i  in  1  EX-stage resolved taken branch/jump
branch_target__i  in  WIDTH  redirect address, valid with branch_taken__i
adder_a__o  out  WIDTH  equals pc__o; feeds adder operand A
adder_b__o  out  WIDTH  constant INCR; feeds adder operand B
seq_next__i  in  WIDTH  adder result (PC+INCR)
imem_req__o  out  1  fetch request
imem_addr__o  out  WIDTH  fetch address, equals pc__o
imem_ready__i  in  1  memory returns imem_data__i this cycle
imem_data__i  in  32  fetched instruction
pc__o  out  WIDTH  current PC register
ifid_valid__o  out  1  IF/ID holds a real instruction
ifid_instr__o  out  32  IF/ID instruction
ifid_pc4__o  out  WIDTH  IF/ID PC+INCR
align_err__o  out  1  sticky misaligned-redirect flag

Behaviour:
- Reset: asynchronous, active-low. Outputs while rst_n__i is low and on release:
  - pc__o = RESET_PC
  - ifid_valid__o = 0, ifid_instr__o = 0, ifid_pc4__o = 0
  - align_err__o = 0
  - FSM = BOOT
- Reset mid-operation: the above state is entered immediately and any in-flight fetch is dropped.
- FSM states:
  - BOOT: imem_req__o = 0. Go to RUN on the next clock.
  - RUN: normal operation.
  - HALT: imem_req__o = 0, PC frozen, ifid_valid__o = 0. Leave HALT only through reset.
- imem_req__o = (state == RUN) && !stall__i.
- imem_addr__o, adder_a__o and pc__o are all the PC register, combinationally. adder_b__o is always INCR.
- Fetch completes in any cycle where imem_req__o && imem_ready__i.
- Per-cycle priority in RUN, highest first:
  1. branch_taken__i with branch_target__i[1:0] != 0:
     - align_err__o <= 1, ifid_valid__o <= 0, go to HALT.
     - PC unchanged.
  2. branch_taken__i with an aligned target:
     - pc <= branch_target__i, ifid_valid__o <= 0.
     - Overrides stall__i, and discards any fetch completing in the same cycle.
  3. stall__i:
     - PC, ifid_valid__o, ifid_instr__o and ifid_pc4__o all hold.
  4. Fetch complete:
     - pc <= seq_next__i.
     - ifid_instr__o <= imem_data__i, ifid_pc4__o <= seq_next__i, ifid_valid__o <= 1.
  5. Otherwise (memory not ready):
     - PC holds, ifid_valid__o <= 0 (bubble). ifid_instr__o and ifid_pc4__o keep their old values.
- Latency: an instruction enters IF/ID on the clock edge after its fetch completes. A redirect takes effect on the PC one cycle after branch_taken__i. The first post-reset request is in the second cycle after reset release.
- Arithmetic: the block adds nothing itself. seq_next__i is taken as-is; wrap-around is modulo 2^WIDTH (0xFFFF_FFFC -> 0x0000_0000) and is legal, not an error.
- Branch in BOOT: ignored. No branch can be resolved before the first fetch.

Optional Feature:
PC_FETCH_PERF_EN
- Defined: adds two outputs, perf_fetch__o[31:0] and perf_bubble__o[31:0].
  - perf_fetch__o counts cycles where ifid_valid__o is loaded with 1.
  - perf_bubble__o counts RUN cycles with no stall where ifid_valid__o is loaded with 0.
  - Both counters saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: neither port nor either counter exists. All other behaviour is identical.

Test Plan:
1. Reset release with imem_ready__i = 1 held:
   - cycle 0: imem_req__o = 0 (BOOT).
   - cycle 1: imem_addr__o = 0x0.
   - following edges: PC steps 0x4, 0x8.
   - ifid_pc4__o = 0x4 with ifid_valid__o = 1 one cycle after the first fetch.
2. stall__i high for 3 cycles at PC = 0x8:
   - imem_req__o = 0 throughout; PC holds 0x8; IF/ID contents and valid held.
   - Fetching resumes at 0x8 once the stall drops.
3. branch_taken__i = 1, target 0x100, together with stall__i = 1 and imem_ready__i = 1:
   - next cycle pc__o = 0x100, ifid_valid__o = 0.
   - the following fetch returns from 0x100.
4. imem_ready__i = 0 for 2 cycles at PC = 0x20:
   - two bubbles (ifid_valid__o = 0); PC stays 0x20.
   - on ready, IF/ID gets the instruction with ifid_pc4__o = 0x24.
5. branch_target__i = 0x102 taken:
   - align_err__o = 1, FSM enters HALT, imem_req__o = 0 indefinitely.
   - asserting rst_n__i low clears the flag and returns pc__o to RESET_PC.
6. Wrap-around: force PC to 0xFFFF_FFFC via a branch, fetch completes:
   - pc__o = 0x0000_0000, ifid_pc4__o = 0x0, no error.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch front end: PC register, fetch request, branch redirect, stall and IF/ID load.
// Optional macro PC_FETCH_PERF_EN adds saturating fetch/bubble performance counters.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch request
// RUN   | normal fetch, redirect and stall handling
// HALT  | misaligned redirect seen; frozen until reset
module pc_fetch_stage #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_0000,
  parameter int unsigned       INCR     = 4
) (
  input  logic             clk__i,
  input  logic             rst_n__i,
  input  logic             stall__i,
  input  logic             branch_taken__i,
  input  logic [WIDTH-1:0] branch_target__i,
  output logic [WIDTH-1:0] adder_a__o,
  output logic [WIDTH-1:0] adder_b__o,
  input  logic [WIDTH-1:0] seq_next__i,
  output logic             imem_req__o,
  output logic [WIDTH-1:0] imem_addr__o,
  input  logic             imem_ready__i,
  input  logic [31:0]      imem_data__i,
  output logic [WIDTH-1:0] pc__o,
  output logic             ifid_valid__o,
  output logic [31:0]      ifid_instr__o,
  output logic [WIDTH-1:0] ifid_pc4__o,
  output logic             align_err__o
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch__o,
  output logic [31:0]      perf_bubble__o
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] pc4_q, pc4_d;
  logic             err_q, err_d;
  logic             fetch_load;
  logic             bubble_load;

  assign imem_req__o   = (state_q == ST_RUN) && !stall__i;
  assign imem_addr__o  = pc_q;
  assign adder_a__o    = pc_q;
  assign adder_b__o    = WIDTH'(INCR);
  assign pc__o         = pc_q;
  assign ifid_valid__o = valid_q;
  assign ifid_instr__o = instr_q;
  assign ifid_pc4__o   = pc4_q;
  assign align_err__o  = err_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    err_d       = err_q;
    fetch_load  = 1'b0;
    bubble_load = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        bubble_load = !stall__i;
        if (branch_taken__i && (branch_target__i[1:0] != 2'b00)) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = ST_HALT;
        end else if (branch_taken__i) begin
          // redirect wins over stall and drops a fetch returning this cycle
          pc_d    = branch_target__i;
          valid_d = 1'b0;
        end else if (stall__i) begin
          pc_d = pc_q;
        end else if (imem_ready__i) begin
          pc_d        = seq_next__i;
          instr_d     = imem_data__i;
          pc4_d       = seq_next__i;
          valid_d     = 1'b1;
          fetch_load  = 1'b1;
          bubble_load = 1'b0;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_HALT: valid_d = 1'b0;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk__i or negedge rst_n__i) begin
    if (!rst_n__i) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      err_q   <= err_d;
    end
  end

`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_fetch_d  = perf_fetch_q;
    perf_bubble_d = perf_bubble_q;
    if (fetch_load && (perf_fetch_q != 32'hFFFF_FFFF))
      perf_fetch_d = perf_fetch_q + 32'd1;
    if (bubble_load && (perf_bubble_q != 32'hFFFF_FFFF))
      perf_bubble_d = perf_bubble_q + 32'd1;
  end

  always_ff @(posedge clk__i or negedge rst_n__i) begin
    if (!rst_n__i) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch__o  = perf_fetch_q;
  assign perf_bubble__o = perf_bubble_q;
`else
  logic unused_perf;
  assign unused_perf = fetch_load ^ bubble_load;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed stimulus, behavioural model, negedge compare.
module tb_pc_fetch_stage;
  localparam logic [31:0] KEY = 32'hA5C3_0000;

  logic        clk, rst_n, stall, br, ready;
  logic [31:0] tgt, adder_a, adder_b, seq_next, addr, pc, instr, pc4, data;
  logic        req, valid, err;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_bubble;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // model of the architectural state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_err, m_booted, m_halted;
  int          m_fetches, m_bubbles;

  pc_fetch_stage dut (
    .clk__i(clk), .rst_n__i(rst_n), .stall__i(stall),
    .branch_taken__i(br), .branch_target__i(tgt),
    .adder_a__o(adder_a), .adder_b__o(adder_b), .seq_next__i(seq_next),
    .imem_req__o(req), .imem_addr__o(addr), .imem_ready__i(ready), .imem_data__i(data),
    .pc__o(pc), .ifid_valid__o(valid), .ifid_instr__o(instr), .ifid_pc4__o(pc4),
    .align_err__o(err)
`ifdef PC_FETCH_PERF_EN
    , .perf_fetch__o(perf_fetch), .perf_bubble__o(perf_bubble)
`endif
  );

  // the downstream adder and an instruction memory whose word encodes its address
  assign seq_next = adder_a + adder_b;
  assign data     = KEY ^ addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_err = 1'b0; m_booted = 1'b0; m_halted = 1'b0;
      m_fetches = 0; m_bubbles = 0;
    end else if (!m_booted) begin
      m_booted = 1'b1;
    end else if (!m_halted) begin
      if (!stall && !(ready && !br)) m_bubbles++;
      if (br && (tgt % 4 != 0)) begin
        m_err = 1'b1; m_halted = 1'b1; m_valid = 1'b0;
      end else if (br) begin
        m_pc = tgt; m_valid = 1'b0;
      end else if (!stall) begin
        if (ready) begin
          m_instr = KEY ^ m_pc;
          m_pc    = m_pc + 32'd4;
          m_pc4   = m_pc;
          m_valid = 1'b1;
          m_fetches++;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("imem_addr", addr, m_pc);
    chk("adder_a", adder_a, m_pc);
    chk("adder_b", adder_b, 32'd4);
    chk("imem_req", {31'd0, req}, {31'd0, m_booted && !m_halted && !stall});
    chk("ifid_valid", {31'd0, valid}, {31'd0, m_valid});
    chk("ifid_instr", instr, m_instr);
    chk("ifid_pc4", pc4, m_pc4);
    chk("align_err", {31'd0, err}, {31'd0, m_err});
`ifdef PC_FETCH_PERF_EN
    chk("perf_fetch", perf_fetch, 32'(m_fetches));
    chk("perf_bubble", perf_bubble, 32'(m_bubbles));
`endif
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rdy_pat, stl_pat;
    rst_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = 32'h0; ready = 1'b1;
    #12 rst_n = 1'b1;
    #1;
    chk("boot_req", {31'd0, req}, 32'd0);
    chk("boot_pc", pc, 32'h0);
    step(1);
    chk("first_addr", addr, 32'h0);
    chk("first_req", {31'd0, req}, 32'd1);
    step(1);
    chk("first_pc4", pc4, 32'h4);
    chk("first_valid", {31'd0, valid}, 32'd1);
    step(1);
    chk("pc_8", pc, 32'h8);
    stall = 1'b1;
    step(3);
    chk("stall_pc", pc, 32'h8);
    chk("stall_req", {31'd0, req}, 32'd0);
    chk("stall_pc4", pc4, 32'h8);
    stall = 1'b0;
    step(1);
    chk("resume_pc", pc, 32'hC);
    chk("resume_instr", instr, KEY ^ 32'h8);
    br = 1'b1; tgt = 32'h100; stall = 1'b1;
    step(1);
    chk("redirect_pc", pc, 32'h100);
    chk("redirect_valid", {31'd0, valid}, 32'd0);
    br = 1'b0; stall = 1'b0;
    step(1);
    chk("target_instr", instr, KEY ^ 32'h100);
    chk("target_pc4", pc4, 32'h104);
    br = 1'b1; tgt = 32'h20;
    step(1);
    br = 1'b0; ready = 1'b0;
    step(2);
    chk("bubble_pc", pc, 32'h20);
    chk("bubble_valid", {31'd0, valid}, 32'd0);
    ready = 1'b1;
    step(1);
    chk("ready_pc4", pc4, 32'h24);
    chk("ready_valid", {31'd0, valid}, 32'd1);
    br = 1'b1; tgt = 32'hFFFF_FFFC;
    step(1);
    br = 1'b0;
    step(1);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", pc4, 32'h0);
    chk("wrap_err", {31'd0, err}, 32'd0);
    step(1);
    br = 1'b1; tgt = 32'h102;
    step(1);
    chk("halt_err", {31'd0, err}, 32'd1);
    chk("halt_pc", pc, 32'h4);
    chk("halt_req", {31'd0, req}, 32'd0);
    tgt = 32'h200;
    step(1);
    br = 1'b0;
    step(3);
    chk("halt_hold_pc", pc, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    step(1);
    rst_n = 1'b1; br = 1'b1; tgt = 32'h300;
    step(1);
    chk("boot_branch_ignored", pc, 32'h0);
    br = 1'b0;
    rdy_pat = 8'b1011_0110;
    stl_pat = 8'b0100_1000;
    for (int i = 0; i < 8; i++) begin
      ready = rdy_pat[i];
      stall = stl_pat[i];
      step(1);
    end
    ready = 1'b1; stall = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
